pwm_cfg_seq: RTL and testbench
==============================

Name: pwm_cfg_seq

Overview:
Configuration sequencer for the 8-channel PWM peripheral. It holds a shadow copy of period, duty and enable for each channel, tracks which channels changed, and replays the changes as single-cycle register writes on the peripheral bus (cs/wr/rd/addr/d_in). Round-robin channel service. It replaces the free-running counter that previously drove the bus, so the host updates channels asynchronously to bus activity.

Parameters:
DW, 32, bus data width and period/duty width
AW, 8, bus address width
BASE_ADDR, 8'h00, address of channel 0 period register
GAP_CYCLES, 1, idle bus cycles after each channel burst (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
ld  in  1  load strobe: write ld_period/ld_duty/ld_en into shadow of ld_ch
ld_ch  in  3  target channel for ld
ld_period  in  DW  period value
ld_duty  in  DW  duty value
ld_en  in  1  channel enable value
flush  in  1  mark all 8 channels dirty (full rewrite)
busy  out  1  high while any channel is dirty or a burst is in flight
done  out  1  one-cycle pulse when the sequencer returns to IDLE with no dirty channel
cs  out  1  bus chip select
wr  out  1  bus write strobe
rd  out  1  bus read strobe, constant 0
addr  out  AW  bus register address
d_in  out  DW  bus write data to peripheral
clamped  out  1  one-cycle pulse when a written duty was clamped (0 without the optional feature)

Behaviour:
- Reset (asynchronous, immediate): state IDLE; shadows period=0, duty=0, en=0; dirty=8'h00; ptr=0; cs=wr=rd=0, addr=0, d_in=0, busy=0, done=0, clamped=0. A reset during a burst drops cs/wr at once; no partial-write recovery.
- Address map: addr = BASE_ADDR + ch*4 + r, where r=0 period, 1 duty, 2 enable; r=3 unused. Arithmetic truncates to AW bits.
- Shadow load: on ld, the shadow of ld_ch is overwritten and dirty[ld_ch] is set. flush sets all dirty bits. ld and flush in the same cycle: both take effect.
- States: IDLE, SEL, WR_T, WR_D, WR_E, GAP.
- IDLE: if dirty != 0 -> SEL, else stay.
- SEL (1 cycle): pick the first dirty channel searching ptr, ptr+1, ..., wrapping mod 8. Capture its shadow into working regs and clear its dirty bit. Set ptr = ch+1 mod 8. If ld hits the same channel in this cycle, dirty stays set and the new values are captured on a later service (ld wins over clear). Next state is WR_T.
- WR_T / WR_D / WR_E: one cycle each, cs=wr=1. addr per map. d_in is respectively working period, working duty, and {(DW-1)'b0, en}.
- GAP: cs=wr=0 for GAP_CYCLES cycles, then -> IDLE.
- Outside WR_* states: cs=wr=0. addr and d_in hold their last values.
- Latency: ld to first write (WR_T) = 2 cycles when idle (IDLE, SEL). Per-channel cost = 4 + GAP_CYCLES cycles.
- ld on a channel mid-burst does not alter in-flight data. The channel is rewritten later with the new values.
- busy = (state != IDLE) | (dirty != 0), registered.
- done pulses in the cycle after the GAP->IDLE transition when dirty == 0.

Optional Feature:
Macro PWM_DUTY_CLAMP_EN.
- Defined: at SEL, if the captured duty > captured period (unsigned), the working duty is set to the period, and clamped pulses during WR_D.
- Undefined: duty is passed unchanged and clamped is tied to 0.

Test Plan:
- Reset release, no stimulus -> cs=wr=rd=0, busy=0, done never pulses over 50 cycles.
- ld ch3 with period=1000, duty=250, en=1 while idle -> 2 cycles later three consecutive writes addr 0x0C/0x0D/0x0E with d_in 1000/250/1, then 1 gap cycle, then done pulse, busy=0.
- flush after reset -> 24 writes, channel order 0..7, 5 cycles per channel, all d_in=0, single done at the end.
- ptr=5 (after servicing ch4), then ld ch1 and ch6 in the same cycle -> ch6 burst precedes ch1 burst.
- ld ch2 duty=10 and then, during WR_D of ch2, ld ch2 duty=20 -> first burst writes 10, a second ch2 burst writes 20.
- With PWM_DUTY_CLAMP_EN defined: ld ch0 period=100, duty=300 -> WR_D writes 100 and clamped=1 for that cycle. Without the macro: writes 300 and clamped=0.
- Assert rst during WR_D -> cs=wr=0 immediately, busy=0, dirty cleared, and no writes after reset release.

Source files
------------

// File: rtl/pwm_cfg_seq_if.sv
// pwm_cfg_seq_if -- register-write bus between the PWM configuration
// sequencer and the PWM peripheral register file.
//
// Signals
//   cs    chip select
//   wr    write strobe
//   rd    read strobe (the sequencer never reads, so it is held low)
//   addr  register address, AW bits
//   d_in  write data into the peripheral, DW bits
//
// Modports
//   master  driven by the sequencer
//   slave   seen by the peripheral (or a bus monitor)
interface pwm_cfg_seq_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic          cs;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] d_in;

  modport master (output cs, output wr, output rd, output addr, output d_in);
  modport slave  (input  cs, input  wr, input  rd, input  addr, input  d_in);
endinterface

// File: rtl/pwm_cfg_seq.sv
// pwm_cfg_seq -- configuration sequencer for the 8-channel PWM peripheral.
//
// Keeps a shadow copy of period/duty/enable for every channel, marks a
// channel dirty when the host loads it (or on flush), and replays each dirty
// channel as a burst of three single-cycle register writes
// (period, duty, enable) followed by GAP_CYCLES idle bus cycles. Dirty
// channels are served round-robin starting after the last one served.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   ld         load strobe: write ld_period/ld_duty/ld_en into shadow of ld_ch
//   ld_ch      target channel of ld
//   ld_period  period value (DW bits)
//   ld_duty    duty value (DW bits)
//   ld_en      enable value
//   flush      mark all 8 channels dirty
//   busy       registered: sequencer not idle or some channel dirty
//   done       one-cycle pulse on return to IDLE with nothing dirty
//   clamped    one-cycle pulse during a duty write whose value was clamped
//   bus        pwm_cfg_seq_if.master: cs/wr/rd/addr/d_in
//
// Build option
//   PWM_DUTY_CLAMP_EN  when defined, a duty larger than the period is
//                      written as the period and clamped pulses on that
//                      write; when undefined duty passes unchanged and
//                      clamped stays 0.
module pwm_cfg_seq #(
  parameter int            DW         = 32,
  parameter int            AW         = 8,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter int            GAP_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [2:0]    ld_ch,
  input  logic [DW-1:0] ld_period,
  input  logic [DW-1:0] ld_duty,
  input  logic          ld_en,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic          clamped,
  pwm_cfg_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, SEL, WR_T, WR_D, WR_E, GAP} state_t;

  state_t        state, state_next;

  logic [DW-1:0] period_sh [8];
  logic [DW-1:0] duty_sh   [8];
  logic [7:0]    en_sh;
  logic [7:0]    dirty, dirty_next;
  logic [2:0]    ptr;
  logic [2:0]    sel_ch;
  logic [2:0]    idx;
  logic          found;
  logic [2:0]    ch_reg;
  logic [DW-1:0] work_duty;
  logic          work_en;
  logic          clamp_hit;
  logic [DW-1:0] duty_sel;
  logic          clamp_sel;
  logic [15:0]   gap_cnt;
  logic          gap_last;

  logic          cs_reg, wr_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] d_reg;
  logic          busy_reg, done_reg, clamped_reg;

  function automatic logic [AW-1:0] reg_addr(input logic [2:0] ch, input logic [1:0] r);
    // {ch, r} == ch*4 + r; the sum wraps at AW bits
    return BASE_ADDR + AW'({ch, r});
  endfunction

  // First dirty channel at or after ptr, wrapping mod 8
  always_comb begin
    sel_ch = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && dirty[idx]) begin
        sel_ch = idx;
        found  = 1'b1;
      end
    end
  end

`ifdef PWM_DUTY_CLAMP_EN
  assign clamp_sel = (duty_sh[sel_ch] > period_sh[sel_ch]);
  assign duty_sel  = clamp_sel ? period_sh[sel_ch] : duty_sh[sel_ch];
`else
  assign clamp_sel = 1'b0;
  assign duty_sel  = duty_sh[sel_ch];
`endif

  // Dirty tracking: a load in the same cycle as the SEL clear wins, so the
  // channel gets another pass with the freshly loaded values.
  always_comb begin
    dirty_next = dirty;
    if (state == SEL) dirty_next[sel_ch] = 1'b0;
    if (flush)        dirty_next = 8'hFF;
    if (ld)           dirty_next[ld_ch] = 1'b1;
  end

  assign gap_last = (gap_cnt == 16'(GAP_CYCLES - 1));

  // Next state. The last gap cycle goes straight to SEL when more work is
  // pending, so back-to-back channels cost 4 + GAP_CYCLES cycles each.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dirty != 8'h00) state_next = SEL;
      SEL:     state_next = WR_T;
      WR_T:    state_next = WR_D;
      WR_D:    state_next = WR_E;
      WR_E:    state_next = GAP;
      GAP:     if (gap_last) state_next = (dirty != 8'h00) ? SEL : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Shadow registers and dirty mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        period_sh[i] <= '0;
        duty_sh[i]   <= '0;
      end
      en_sh <= 8'h00;
      dirty <= 8'h00;
    end else begin
      if (ld) begin
        period_sh[ld_ch] <= ld_period;
        duty_sh[ld_ch]   <= ld_duty;
        en_sh[ld_ch]     <= ld_en;
      end
      dirty <= dirty_next;
    end
  end

  // Working copy captured at SEL so later loads do not disturb a burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 3'd0;
      ch_reg    <= 3'd0;
      work_duty <= '0;
      work_en   <= 1'b0;
      clamp_hit <= 1'b0;
    end else if (state == SEL) begin
      ptr       <= sel_ch + 3'd1;
      ch_reg    <= sel_ch;
      work_duty <= duty_sel;
      work_en   <= en_sh[sel_ch];
      clamp_hit <= clamp_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                gap_cnt <= '0;
    else if (state != GAP)  gap_cnt <= '0;
    else                    gap_cnt <= gap_cnt + 16'd1;
  end

  // Registered bus outputs, loaded from state_next so they line up with the
  // WR_* states; addr/d_in hold between bursts. During SEL->WR_T the
  // channel is not yet in ch_reg, hence sel_ch and the shadow directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      addr_reg    <= '0;
      d_reg       <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      clamped_reg <= 1'b0;
    end else begin
      cs_reg      <= (state_next == WR_T) || (state_next == WR_D) || (state_next == WR_E);
      wr_reg      <= (state_next == WR_T) || (state_next == WR_D) || (state_next == WR_E);
      busy_reg    <= (state_next != IDLE) || (dirty_next != 8'h00);
      done_reg    <= (state == GAP) && (state_next == IDLE) && (dirty_next == 8'h00);
      clamped_reg <= (state_next == WR_D) && clamp_hit;
      case (state_next)
        WR_T: begin
          addr_reg <= reg_addr(sel_ch, 2'd0);
          d_reg    <= period_sh[sel_ch];
        end
        WR_D: begin
          addr_reg <= reg_addr(ch_reg, 2'd1);
          d_reg    <= work_duty;
        end
        WR_E: begin
          addr_reg <= reg_addr(ch_reg, 2'd2);
          d_reg    <= DW'(work_en);
        end
        default: ;
      endcase
    end
  end

  assign bus.cs   = cs_reg;
  assign bus.wr   = wr_reg;
  assign bus.rd   = 1'b0;
  assign bus.addr = addr_reg;
  assign bus.d_in = d_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign clamped  = clamped_reg;

endmodule

// File: tb/tb_pwm_cfg_seq.sv
// tb_pwm_cfg_seq -- directed self-checking bench for pwm_cfg_seq.
// A monitor logs every bus write (one line per write) into a queue; the main
// process drives vectors on the falling edge and checks cycle by cycle or
// against the logged writes.
module tb_pwm_cfg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld;
  logic [2:0]  ld_ch;
  logic [31:0] ld_period;
  logic [31:0] ld_duty;
  logic        ld_en;
  logic        flush;
  logic        busy, done, clamped;

  pwm_cfg_seq_if #(.DW(32), .AW(8)) bus_if ();

  pwm_cfg_seq #(.DW(32), .AW(8), .BASE_ADDR(8'h00), .GAP_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .ld_ch     (ld_ch),
    .ld_period (ld_period),
    .ld_duty   (ld_duty),
    .ld_en     (ld_en),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .clamped   (clamped),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t wq[$];
  int  cyc       = 0;
  int  done_cnt  = 0;
  int  checks    = 0;
  int  errors    = 0;

  // Monitor samples 2 ns after the rising edge
  always @(posedge clk) begin
    #2;
    cyc++;
    if (bus_if.cs && bus_if.wr) begin
      wq.push_back('{a: bus_if.addr, d: bus_if.d_in, c: cyc});
      $display("[%0t] write addr=0x%02h data=%0d", $time, bus_if.addr, bus_if.d_in);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Returns at the falling edge of the cycle after ld was sampled
  task automatic load(input logic [2:0] ch, input logic [31:0] p, input logic [31:0] d, input logic e);
    ld = 1'b1; ld_ch = ch; ld_period = p; ld_duty = d; ld_en = e;
    step();
    ld = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      step();
      n++;
    end
    chk("done_timeout", {31'b0, done}, 1);
    step();
  endtask

  int n0, d0;
`ifdef PWM_DUTY_CLAMP_EN
  localparam logic [31:0] CLAMP_DUTY = 32'd100;
  localparam logic        CLAMP_FLAG = 1'b1;
`else
  localparam logic [31:0] CLAMP_DUTY = 32'd300;
  localparam logic        CLAMP_FLAG = 1'b0;
`endif

  initial begin
    rst = 1'b1; ld = 1'b0; ld_ch = '0; ld_period = '0; ld_duty = '0; ld_en = 1'b0; flush = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state and quiet bus
    chk("rst_cs", {31'b0, bus_if.cs}, 0);
    chk("rst_wr", {31'b0, bus_if.wr}, 0);
    chk("rst_rd", {31'b0, bus_if.rd}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_addr", {24'b0, bus_if.addr}, 0);
    chk("rst_d_in", bus_if.d_in, 0);
    chk("rst_clamped", {31'b0, clamped}, 0);
    d0 = done_cnt;
    repeat (50) step();
    chk("idle_done_cnt", done_cnt - d0, 0);
    chk("idle_writes", wq.size(), 0);

    // Flush after reset: 24 zero writes, channels 0..7, 5 cycles apart
    wq.delete();
    d0 = done_cnt;
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_done(200);
    chk("flush_count", wq.size(), 24);
    if (wq.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        chk("flush_addr", {24'b0, wq[i].a}, (i / 3) * 4 + (i % 3));
        chk("flush_data", wq[i].d, 0);
        chk("flush_cycle", wq[i].c - wq[0].c, (i / 3) * 5 + (i % 3));
      end
    end
    chk("flush_done_cnt", done_cnt - d0, 1);
    chk("flush_busy", {31'b0, busy}, 0);

    // Single channel load while idle, cycle by cycle
    load(3'd3, 32'd1000, 32'd250, 1'b1);
    chk("ch3_idle_busy", {31'b0, busy}, 1);
    chk("ch3_idle_cs", {31'b0, bus_if.cs}, 0);
    step();
    chk("ch3_sel_cs", {31'b0, bus_if.cs}, 0);
    step();
    chk("ch3_wrt_cs", {31'b0, bus_if.cs}, 1);
    chk("ch3_wrt_wr", {31'b0, bus_if.wr}, 1);
    chk("ch3_wrt_addr", {24'b0, bus_if.addr}, 32'h0C);
    chk("ch3_wrt_data", bus_if.d_in, 1000);
    step();
    chk("ch3_wrd_addr", {24'b0, bus_if.addr}, 32'h0D);
    chk("ch3_wrd_data", bus_if.d_in, 250);
    chk("ch3_wrd_clamped", {31'b0, clamped}, 0);
    step();
    chk("ch3_wre_addr", {24'b0, bus_if.addr}, 32'h0E);
    chk("ch3_wre_data", bus_if.d_in, 1);
    step();
    chk("ch3_gap_cs", {31'b0, bus_if.cs}, 0);
    chk("ch3_gap_done", {31'b0, done}, 0);
    chk("ch3_gap_addr_hold", {24'b0, bus_if.addr}, 32'h0E);
    step();
    chk("ch3_done", {31'b0, done}, 1);
    chk("ch3_busy", {31'b0, busy}, 0);
    step();
    chk("ch3_done_once", {31'b0, done}, 0);

    // Round robin: serve ch4 (ptr -> 5), then ch1 and ch6 pending together
    load(3'd4, 32'd40, 32'd4, 1'b0);
    wait_done(50);
    wq.delete();
    load(3'd1, 32'd11, 32'd1, 1'b1);
    load(3'd6, 32'd66, 32'd6, 1'b1);
    wait_done(50);
    chk("rr_count", wq.size(), 6);
    if (wq.size() == 6) begin
      chk("rr_first_addr", {24'b0, wq[0].a}, 32'h18);
      chk("rr_first_data", wq[0].d, 66);
      chk("rr_second_addr", {24'b0, wq[3].a}, 32'h04);
      chk("rr_second_data", wq[3].d, 11);
    end

    // Reload during WR_D: in-flight burst keeps 10, a second burst writes 20
    wq.delete();
    load(3'd2, 32'd50, 32'd10, 1'b1);
    step();
    step();
    step();
    chk("mid_wrd_addr", {24'b0, bus_if.addr}, 32'h09);
    load(3'd2, 32'd50, 32'd20, 1'b1);
    wait_done(50);
    chk("mid_count", wq.size(), 6);
    if (wq.size() == 6) begin
      chk("mid_first_duty", wq[1].d, 10);
      chk("mid_second_addr", {24'b0, wq[4].a}, 32'h09);
      chk("mid_second_duty", wq[4].d, 20);
    end

    // Duty above period
    load(3'd0, 32'd100, 32'd300, 1'b1);
    step();
    step();
    step();
    chk("clamp_addr", {24'b0, bus_if.addr}, 32'h01);
    chk("clamp_duty", bus_if.d_in, CLAMP_DUTY);
    chk("clamp_flag", {31'b0, clamped}, {31'b0, CLAMP_FLAG});
    step();
    chk("clamp_flag_end", {31'b0, clamped}, 0);
    wait_done(50);

    // Asynchronous reset in the middle of a burst
    load(3'd5, 32'd7, 32'd3, 1'b1);
    step();
    step();
    step();
    chk("arst_pre_cs", {31'b0, bus_if.cs}, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_cs", {31'b0, bus_if.cs}, 0);
    chk("arst_wr", {31'b0, bus_if.wr}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    n0 = wq.size();
    d0 = done_cnt;
    step();
    step();
    rst = 1'b0;
    repeat (30) step();
    chk("arst_no_writes", wq.size() - n0, 0);
    chk("arst_no_done", done_cnt - d0, 0);
    chk("arst_busy_after", {31'b0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
